// File: rtl/io_shiftreg_pkg.sv
// io_shiftreg_pkg: lane-mode and state types plus lane-count helpers
// shared by the multi-lane serialiser/deserialiser.
package io_shiftreg_pkg;

    typedef enum logic [1:0] {
        MODE_1L   = 2'd0,
        MODE_2L   = 2'd1,
        MODE_4L   = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_e;

    // Reserved modes and modes wider than the physical lanes fall back to 1.
    function automatic logic [2:0] lane_count(mode_e mode, int max_lanes);
        logic [2:0] l;
        unique case (mode)
            MODE_2L: l = 3'd2;
            MODE_4L: l = 3'd4;
            default: l = 3'd1;
        endcase
        if (int'(l) > max_lanes) l = 3'd1;
        return l;
    endfunction

    function automatic logic [1:0] lane_log2(logic [2:0] lanes);
        logic [1:0] lg;
        unique case (1'b1)
            lanes[2]: lg = 2'd2;
            lanes[1]: lg = 2'd1;
            default:  lg = 2'd0;
        endcase
        return lg;
    endfunction

endpackage

// File: rtl/io_shiftreg_align.sv
// io_shiftreg_align: combinational barrel shifter used to place the word
// at the top of the register on load and right-align it on capture.
module io_shiftreg_align #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic [DATA_WIDTH-1:0]  data,
    input  logic [SHAMT_WIDTH-1:0] amount,
    input  logic                   left,
    output logic [DATA_WIDTH-1:0]  result
);

    assign result = left ? (data << amount) : (data >> amount);

endmodule

// File: rtl/io_shiftreg_lanes.sv
// io_shiftreg_lanes: 1/2/4-lane serialiser/deserialiser paced by an
// external shift strobe, with a one-word buffered RX handshake.
module io_shiftreg_lanes
    import io_shiftreg_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_LANES  = 4,
    parameter int LEN_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  clr_i,
    input  logic [1:0]            cfg_mode_i,
    input  logic [LEN_WIDTH-1:0]  cfg_len_i,
    input  logic                  cfg_lsbfirst_i,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    input  logic                  shift_en_i,
    input  logic [MAX_LANES-1:0]  serial_i,
    output logic [MAX_LANES-1:0]  serial_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o,
    input  logic                  rx_ready_i,
    output logic                  busy_o,
    output logic                  done_o
);

    if (DATA_WIDTH % MAX_LANES != 0) begin : g_bad_width
        $error("DATA_WIDTH must be a multiple of MAX_LANES");
    end
    if (MAX_LANES != 1 && MAX_LANES != 2 && MAX_LANES != 4) begin : g_bad_lanes
        $error("MAX_LANES must be 1, 2 or 4");
    end

    state_e                state;
    logic [DATA_WIDTH-1:0] sreg;
    logic [DATA_WIDTH-1:0] sreg_next;
    logic [DATA_WIDTH-1:0] rx_in;
    logic [DATA_WIDTH-1:0] tx_load;
    logic [DATA_WIDTH-1:0] rx_src;
    logic [DATA_WIDTH-1:0] rx_shr;
    logic [DATA_WIDTH-1:0] rx_word;
    logic [DATA_WIDTH-1:0] w_mask;
    logic [LEN_WIDTH-1:0]  cnt;
    logic [LEN_WIDTH-1:0]  cnt_live;
    logic [LEN_WIDTH-1:0]  sh_q;
    logic [LEN_WIDTH-1:0]  sh_live;
    logic [LEN_WIDTH-1:0]  tx_amt;
    logic [LEN_WIDTH-1:0]  rx_amt;
    logic [LEN_WIDTH:0]    w_live;
    logic [2:0]            lanes_q;
    logic [2:0]            lanes_live;
    logic [1:0]            lg_live;
    logic                  lsb_q;
    logic [MAX_LANES-1:0]  lane_mask;
    logic                  last_shift;
    logic                  rx_free;

    // Live config: N-1 = len >> log2(L), W = N*L, pad = DATA_WIDTH - W.
    assign lanes_live = lane_count(mode_e'(cfg_mode_i), MAX_LANES);
    assign lg_live    = lane_log2(lanes_live);
    assign cnt_live   = cfg_len_i >> lg_live;
    assign w_live     = ({1'b0, cnt_live} + (LEN_WIDTH+1)'(1)) << lg_live;
    assign sh_live    = LEN_WIDTH'(DATA_WIDTH - int'(w_live));

    always_comb begin
        lane_mask = '0;
        for (int k = 0; k < MAX_LANES; k++) begin
            lane_mask[k] = (k < int'(lanes_q));
        end
    end

    assign rx_in = DATA_WIDTH'(serial_i & lane_mask);

    assign sreg_next = lsb_q
        ? ((sreg >> lanes_q) | (rx_in << (DATA_WIDTH - int'(lanes_q))))
        : ((sreg << lanes_q) | rx_in);

    always_comb begin
        serial_o = '0;
        if (state != IDLE) begin
            if (lsb_q) begin
                serial_o = sreg[MAX_LANES-1:0] & lane_mask;
            end else begin
                serial_o = MAX_LANES'(sreg >> (DATA_WIDTH - int'(lanes_q)))
                         & lane_mask;
            end
        end
    end

    assign tx_amt = cfg_lsbfirst_i ? '0 : sh_live;

    io_shiftreg_align #(
        .DATA_WIDTH  (DATA_WIDTH),
        .SHAMT_WIDTH (LEN_WIDTH)
    ) u_tx_align (
        .data   (tx_data_i),
        .amount (tx_amt),
        .left   (1'b1),
        .result (tx_load)
    );

    // On the final strobe the word is captured from the post-shift value.
    assign rx_src = (state == HOLD) ? sreg : sreg_next;
    assign rx_amt = lsb_q ? sh_q : '0;

    io_shiftreg_align #(
        .DATA_WIDTH  (DATA_WIDTH),
        .SHAMT_WIDTH (LEN_WIDTH)
    ) u_rx_align (
        .data   (rx_src),
        .amount (rx_amt),
        .left   (1'b0),
        .result (rx_shr)
    );

    assign w_mask     = {DATA_WIDTH{1'b1}} >> sh_q;
    assign rx_word    = lsb_q ? rx_shr : (rx_src & w_mask);
    assign last_shift = (state == SHIFT) && shift_en_i && (cnt == '0);
    assign rx_free    = !rx_valid_o || rx_ready_i;
    assign tx_ready_o = (state == IDLE);
    assign busy_o     = (state != IDLE);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state      <= IDLE;
            sreg       <= '0;
            cnt        <= '0;
            sh_q       <= '0;
            lanes_q    <= 3'd1;
            lsb_q      <= 1'b0;
            rx_data_o  <= '0;
            rx_valid_o <= 1'b0;
            done_o     <= 1'b0;
        end else if (clr_i) begin
            state      <= IDLE;
            sreg       <= '0;
            cnt        <= '0;
            rx_valid_o <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (rx_ready_i) rx_valid_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (tx_valid_i) begin
                        state   <= SHIFT;
                        sreg    <= tx_load;
                        cnt     <= cnt_live;
                        sh_q    <= sh_live;
                        lanes_q <= lanes_live;
                        lsb_q   <= cfg_lsbfirst_i;
                    end
                end
                SHIFT: begin
                    if (shift_en_i) begin
                        sreg <= sreg_next;
                        if (cnt != '0) cnt <= cnt - LEN_WIDTH'(1);
                    end
                    if (last_shift) begin
                        if (rx_free) begin
                            rx_data_o  <= rx_word;
                            rx_valid_o <= 1'b1;
                            done_o     <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (rx_ready_i) begin
                        rx_data_o  <= rx_word;
                        rx_valid_o <= 1'b1;
                        done_o     <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_io_shiftreg_lanes.sv
// tb_io_shiftreg_lanes: directed and randomized words checked against a
// bit-position model of the lane ordering and RX alignment.
module tb_io_shiftreg_lanes;

    logic        clk = 1'b0;
    logic        rstn_i;
    logic        clr_i;
    logic [1:0]  cfg_mode_i;
    logic [4:0]  cfg_len_i;
    logic        cfg_lsbfirst_i;
    logic [31:0] tx_data_i;
    logic        tx_valid_i;
    logic        tx_ready_o;
    logic        shift_en_i;
    logic [3:0]  serial_i;
    logic [3:0]  serial_o;
    logic [31:0] rx_data_o;
    logic        rx_valid_o;
    logic        rx_ready_i;
    logic        busy_o;
    logic        done_o;

    int n_tests = 0;
    int n_fail  = 0;

    int          m_l;
    int          m_n;
    int          m_w;
    bit          m_lsb;
    logic [31:0] m_tx;
    logic [31:0] m_rx;
    logic [31:0] saved;

    always #5 clk = ~clk;

    io_shiftreg_lanes u_dut (
        .clk_i          (clk),
        .rstn_i         (rstn_i),
        .clr_i          (clr_i),
        .cfg_mode_i     (cfg_mode_i),
        .cfg_len_i      (cfg_len_i),
        .cfg_lsbfirst_i (cfg_lsbfirst_i),
        .tx_data_i      (tx_data_i),
        .tx_valid_i     (tx_valid_i),
        .tx_ready_o     (tx_ready_o),
        .shift_en_i     (shift_en_i),
        .serial_i       (serial_i),
        .serial_o       (serial_o),
        .rx_data_o      (rx_data_o),
        .rx_valid_o     (rx_valid_o),
        .rx_ready_i     (rx_ready_i),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Word bit carried on lane k during strobe j.
    function automatic int pos(int j, int k);
        return m_lsb ? (j * m_l + k) : (m_w - m_l - j * m_l + k);
    endfunction

    function automatic logic [3:0] exp_out(int j);
        logic [3:0] o = '0;
        for (int k = 0; k < m_l; k++) o[k] = m_tx[pos(j, k)];
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_word(input logic [31:0] tx, input int len,
                              input int mode, input bit lsb);
        m_l   = (mode == 3) ? 1 : (1 << mode);
        m_n   = (len + m_l) / m_l;
        m_w   = m_n * m_l;
        m_lsb = lsb;
        m_tx  = tx;
        m_rx  = '0;
        check("tx_ready_idle", {31'd0, tx_ready_o}, 32'd1);
        tx_data_i      = tx;
        cfg_len_i      = 5'(len);
        cfg_mode_i     = 2'(mode);
        cfg_lsbfirst_i = lsb;
        tx_valid_i     = 1'b1;
        tick();
        tx_valid_i     = 1'b0;
        tx_data_i      = $urandom;
        cfg_mode_i     = 2'($urandom_range(0, 3));
        cfg_len_i      = 5'($urandom);
        cfg_lsbfirst_i = 1'($urandom);
        check("busy_start", {31'd0, busy_o}, 32'd1);
        check("tx_ready_busy", {31'd0, tx_ready_o}, 32'd0);
    endtask

    // src: 0 random lanes, 1 loopback of the expected TX lanes, 2 all ones
    task automatic shift_some(input int src, input bit rdy_last, input int cnt);
        for (int j = 0; j < cnt; j++) begin
            logic [3:0] o;
            logic [3:0] din;
            repeat ($urandom_range(0, 2)) tick();
            o = exp_out(j);
            check("serial_o", {28'd0, serial_o}, {28'd0, o});
            din = 4'($urandom);
            for (int k = 0; k < m_l; k++) begin
                if (src == 1) din[k] = o[k];
                if (src == 2) din[k] = 1'b1;
                m_rx[pos(j, k)] = din[k];
            end
            serial_i   = din;
            shift_en_i = 1'b1;
            if (rdy_last && j == m_n - 1) rx_ready_i = 1'b1;
            tick();
            shift_en_i = 1'b0;
            rx_ready_i = 1'b0;
            if (j < m_n - 1) check("done_mid", {31'd0, done_o}, 32'd0);
        end
    endtask

    task automatic finish_word(input bit consume);
        check("done", {31'd0, done_o}, 32'd1);
        check("rx_valid", {31'd0, rx_valid_o}, 32'd1);
        check("rx_data", rx_data_o, m_rx);
        check("busy_end", {31'd0, busy_o}, 32'd0);
        if (consume) begin
            rx_ready_i = 1'b1;
            tick();
            rx_ready_i = 1'b0;
            check("done_pulse", {31'd0, done_o}, 32'd0);
            check("rx_cleared", {31'd0, rx_valid_o}, 32'd0);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_tx_ready"}, {31'd0, tx_ready_o}, 32'd1);
        check({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
        check({tag, "_serial"}, {28'd0, serial_o}, 32'd0);
        check({tag, "_rx_valid"}, {31'd0, rx_valid_o}, 32'd0);
        check({tag, "_done"}, {31'd0, done_o}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn_i = 1'b0; clr_i = 1'b0; cfg_mode_i = '0; cfg_len_i = '0;
        cfg_lsbfirst_i = 1'b0; tx_data_i = '0; tx_valid_i = 1'b0;
        shift_en_i = 1'b0; serial_i = '0; rx_ready_i = 1'b0;
        repeat (2) tick();
        check_idle_outputs("reset");
        check("reset_rx_data", rx_data_o, 32'd0);
        rstn_i = 1'b1;
        tick();

        start_word(32'hA5, 7, 0, 0);
        shift_some(1, 0, m_n);
        finish_word(1);
        check("a5_value", rx_data_o, 32'h0000_00A5);

        start_word(32'h1234_5678, 31, 2, 1);
        shift_some(1, 0, m_n);
        finish_word(1);
        check("quad_value", rx_data_o, 32'h1234_5678);

        start_word(32'h2D, 4, 1, 0);
        shift_some(2, 0, m_n);
        finish_word(1);
        check("dual_value", rx_data_o, 32'h0000_003F);

        start_word(32'h01, 0, 3, 0);
        shift_some(0, 0, m_n);
        finish_word(1);

        // Second word stalls in HOLD while the first is unread.
        start_word($urandom, $urandom_range(0, 31), $urandom_range(0, 3), 1'($urandom));
        shift_some(0, 0, m_n);
        finish_word(0);
        saved = m_rx;
        start_word($urandom, $urandom_range(0, 31), $urandom_range(0, 3), 1'($urandom));
        shift_some(0, 0, m_n);
        check("hold_done", {31'd0, done_o}, 32'd0);
        check("hold_busy", {31'd0, busy_o}, 32'd1);
        check("hold_tx_ready", {31'd0, tx_ready_o}, 32'd0);
        check("hold_rx_first", rx_data_o, saved);
        shift_en_i = 1'b1; tx_valid_i = 1'b1; serial_i = 4'($urandom);
        tick();
        serial_i = 4'($urandom);
        tick();
        shift_en_i = 1'b0; tx_valid_i = 1'b0;
        check("hold_busy2", {31'd0, busy_o}, 32'd1);
        check("hold_rx_first2", rx_data_o, saved);
        rx_ready_i = 1'b1;
        tick();
        check("hold_rx_second", rx_data_o, m_rx);
        check("hold_rx_valid", {31'd0, rx_valid_o}, 32'd1);
        check("hold_done_pulse", {31'd0, done_o}, 32'd1);
        check("hold_idle", {31'd0, busy_o}, 32'd0);
        tick();
        rx_ready_i = 1'b0;
        check("hold_rx_cleared", {31'd0, rx_valid_o}, 32'd0);
        check("hold_done_once", {31'd0, done_o}, 32'd0);

        // Buffer freed by rx_ready on the final strobe: no HOLD.
        start_word($urandom, $urandom_range(0, 31), $urandom_range(0, 3), 1'($urandom));
        shift_some(0, 0, m_n);
        finish_word(0);
        start_word($urandom, $urandom_range(0, 31), $urandom_range(0, 3), 1'($urandom));
        shift_some(0, 1, m_n);
        finish_word(1);

        // Abort after 3 of 8 strobes with the buffer full.
        start_word($urandom, 7, 0, 0);
        shift_some(0, 0, m_n);
        finish_word(0);
        start_word($urandom, 7, 0, 0);
        shift_some(1, 0, 3);
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        check_idle_outputs("clr");
        clr_i = 1'b1; tx_valid_i = 1'b1;
        tick();
        clr_i = 1'b0; tx_valid_i = 1'b0;
        check("clr_tx_discard", {31'd0, busy_o}, 32'd0);

        // Asynchronous reset mid-shift.
        start_word(32'hA5, 7, 0, 0);
        shift_some(1, 0, 3);
        #2 rstn_i = 1'b0;
        #1;
        check_idle_outputs("arst");
        check("arst_rx_data", rx_data_o, 32'd0);
        #3 rstn_i = 1'b1;
        tick();
        start_word(32'hA5, 7, 0, 0);
        shift_some(1, 0, m_n);
        finish_word(1);
        check("arst_a5", rx_data_o, 32'h0000_00A5);

        for (int i = 0; i < 40; i++) begin
            start_word($urandom, $urandom_range(0, 31), $urandom_range(0, 3),
                       1'($urandom));
            shift_some($urandom_range(0, 2), 0, m_n);
            finish_word(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
